// File: rtl/phase_a_iter_ctrl_if.sv
// Control and phase_a bus between the iteration sequencer and its environment.
// The sequencer (slave) drives the phase_a operand/launch and the run status.
interface phase_a_iter_ctrl_if #(
    parameter int Size  = 3072,
    parameter int Cnt_w = 7
);
    logic             start;
    logic             abort;
    logic [Size-1:0]  a_in;
    logic [Cnt_w-1:0] iter_num;
    logic [Size-1:0]  pa_a;
    logic             pa_en;
    logic [Size-1:0]  pa_new_a;
    logic             pa_en_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [Size-1:0]  result;
    logic [Cnt_w-1:0] iter_cnt;

    modport master (
        output start, abort, a_in, iter_num, pa_new_a, pa_en_out,
        input  pa_a, pa_en, busy, done, err, result, iter_cnt
    );

    modport slave (
        input  start, abort, a_in, iter_num, pa_new_a, pa_en_out,
        output pa_a, pa_en, busy, done, err, result, iter_cnt
    );
endinterface

// File: rtl/phase_a_iter_ctrl.sv
// Initiator-side sequencer: launches phase_a repeatedly, feeding new_a back as
// the next operand, with a per-pass watchdog and an abort path.
//
// state  | meaning
// IDLE   | waiting for an accepted start
// LAUNCH | single-cycle pa_en pulse, watchdog cleared
// WAIT   | waiting for pa_en_out, watchdog counting
// FIN    | one-cycle done pulse
module phase_a_iter_ctrl #(
    parameter int Size    = 3072,
    parameter int Cnt_w   = 7,
    parameter int Timeout = 255,
    parameter int To_w    = 8
) (
    input logic               clk,
    input logic               rst_n,
    phase_a_iter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FIN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [Size-1:0]  r_pa_a;
    logic [Size-1:0]  r_result;
    logic [Cnt_w-1:0] r_iter_num;
    logic [Cnt_w-1:0] r_iter_cnt;
    logic [To_w-1:0]  r_wdog;
    logic             r_err;

    logic w_accept;
    logic w_capture;
    logic w_timeout;
    logic w_last;
    logic w_wdog_tc;
    logic w_pa_en;
    logic w_busy;
    logic w_done;

    assign w_last    = (r_iter_cnt + Cnt_w'(1)) == r_iter_num;
    // Terminal count is hit in the Timeout-th WAIT cycle of a pass.
    assign w_wdog_tc = (r_wdog == To_w'(Timeout - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_pa_en     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (bus.iter_num == '0) ? S_FIN : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_busy = 1'b1;
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_pa_en     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.pa_en_out) begin
                    w_capture   = 1'b1;
                    w_state_nxt = w_last ? S_FIN : S_LAUNCH;
                end else if (w_wdog_tc) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_done      = !bus.abort;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pa_a     <= '0;
            r_result   <= '0;
            r_iter_num <= '0;
            r_iter_cnt <= '0;
            r_wdog     <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pa_a     <= bus.a_in;
                r_iter_num <= bus.iter_num;
                r_iter_cnt <= '0;
                r_err      <= 1'b0;
                if (bus.iter_num == '0) r_result <= bus.a_in;
            end
            if (r_state == S_LAUNCH)    r_wdog <= '0;
            else if (r_state == S_WAIT) r_wdog <= r_wdog + To_w'(1);
            if (w_capture) begin
                r_pa_a     <= bus.pa_new_a;
                r_iter_cnt <= r_iter_cnt + Cnt_w'(1);
                if (w_last) r_result <= bus.pa_new_a;
            end
            if (w_timeout) begin
                r_err    <= 1'b1;
                r_result <= r_pa_a;
            end
        end
    end

    assign bus.pa_a     = r_pa_a;
    assign bus.pa_en    = w_pa_en;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.err      = r_err;
    assign bus.result   = r_result;
    assign bus.iter_cnt = r_iter_cnt;
endmodule

// File: tb/tb_phase_a_iter_ctrl.sv
// Bench for phase_a_iter_ctrl: behavioural phase_a stub (new_a = a + 1) and
// a result scoreboard filled at start and drained at done.
module tb_phase_a_iter_ctrl;
    localparam int Size    = 3072;
    localparam int Cnt_w   = 7;
    localparam int Timeout = 20;
    localparam int To_w    = 8;

    typedef logic [Size-1:0] op_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    phase_a_iter_ctrl_if #(.Size(Size), .Cnt_w(Cnt_w)) bus ();

    phase_a_iter_ctrl #(.Size(Size), .Cnt_w(Cnt_w), .Timeout(Timeout), .To_w(To_w)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;
    op_t sb_q[$];
    op_t last_exp = '0;

    always @(posedge clk) cyc = cyc + 1;

    // phase_a stub: en_out pulses stub_lat cycles after the launch cycle
    bit  stub_on  = 1'b1;
    int  stub_lat = 12;
    int  stub_cd  = -1;
    op_t stub_a   = '0;
    always @(negedge clk) begin
        bus.pa_en_out = 1'b0;
        if (stub_cd == 0) begin
            bus.pa_en_out = 1'b1;
            bus.pa_new_a  = stub_a + op_t'(1);
        end
        if (stub_cd >= 0) stub_cd = stub_cd - 1;
        if (bus.pa_en && stub_on) begin
            stub_a  = bus.pa_a;
            stub_cd = stub_lat - 1;
        end
    end

    int  en_cnt = 0, en_dbl = 0, done_cnt = 0, en_cyc = 0, done_cyc = 0;
    bit  prev_en = 1'b0;
    op_t en_seq[$];
    always @(negedge clk) begin
        if (bus.pa_en) begin
            if (prev_en) en_dbl = en_dbl + 1;
            en_cnt = en_cnt + 1;
            en_cyc = cyc;
            en_seq.push_back(bus.pa_a);
        end
        prev_en = bus.pa_en;
        if (bus.done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic clr_mon();
        en_cnt   = 0;
        en_dbl   = 0;
        done_cnt = 0;
        en_seq.delete();
    endtask

    task automatic drive_start(input op_t a, input logic [Cnt_w-1:0] n);
        @(negedge clk);
        bus.a_in     = a;
        bus.iter_num = n;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
        end
    endtask

    task automatic pop_exp(output op_t e);
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = '1;
        last_exp = e;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.pa_a !== '0)     begin n_err++; $display("FAIL reset_pa_a: got %0h exp 0", bus.pa_a[63:0]); end
        n_vec++; if (bus.pa_en !== 1'b0)  begin n_err++; $display("FAIL reset_pa_en: got %b exp 0", bus.pa_en); end
        n_vec++; if (bus.busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0)   begin n_err++; $display("FAIL reset_done: got %b exp 0", bus.done); end
        n_vec++; if (bus.err !== 1'b0)    begin n_err++; $display("FAIL reset_err: got %b exp 0", bus.err); end
        n_vec++; if (bus.result !== '0)   begin n_err++; $display("FAIL reset_result: got %0h exp 0", bus.result[63:0]); end
        n_vec++; if (bus.iter_cnt !== '0) begin n_err++; $display("FAIL reset_iter_cnt: got %0d exp 0", bus.iter_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_iter3();
        bit  got;
        op_t e;
        clr_mon();
        sb_q.push_back(op_t'(8));
        drive_start(op_t'(5), Cnt_w'(3));
        wait_done(200, got);
        n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL iter3_done_seen: got %b exp 1", got); end
        pop_exp(e);
        n_vec++; if (bus.result !== e)        begin n_err++; $display("FAIL iter3_result: got %0h exp %0h", bus.result[63:0], e[63:0]); end
        n_vec++; if (bus.err !== 1'b0)        begin n_err++; $display("FAIL iter3_err: got %b exp 0", bus.err); end
        n_vec++; if (bus.iter_cnt !== Cnt_w'(3)) begin n_err++; $display("FAIL iter3_iter_cnt: got %0d exp 3", bus.iter_cnt); end
        @(negedge clk);
        n_vec++; if (bus.done !== 1'b0)       begin n_err++; $display("FAIL iter3_done_width: got %b exp 0", bus.done); end
        n_vec++; if (en_cnt != 3)             begin n_err++; $display("FAIL iter3_en_pulses: got %0d exp 3", en_cnt); end
        n_vec++; if (en_dbl != 0)             begin n_err++; $display("FAIL iter3_en_double: got %0d exp 0", en_dbl); end
        n_vec++; if (en_seq.size() != 3)      begin n_err++; $display("FAIL iter3_seq_len: got %0d exp 3", en_seq.size()); end
        for (int i = 0; i < 3 && i < en_seq.size(); i++) begin
            e = op_t'(5 + i);
            n_vec++; if (en_seq[i] !== e) begin n_err++; $display("FAIL iter3_pa_a[%0d]: got %0h exp %0h", i, en_seq[i][63:0], e[63:0]); end
        end
    endtask

    task automatic test_zero();
        op_t e;
        clr_mon();
        sb_q.push_back(op_t'(16'h1234));
        drive_start(op_t'(16'h1234), Cnt_w'(0));
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL zero_done_latency: got %b exp 1", bus.done); end
        pop_exp(e);
        n_vec++; if (bus.result !== e)  begin n_err++; $display("FAIL zero_result: got %0h exp %0h", bus.result[63:0], e[63:0]); end
        n_vec++; if (bus.iter_cnt !== '0) begin n_err++; $display("FAIL zero_iter_cnt: got %0d exp 0", bus.iter_cnt); end
        @(negedge clk);
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL zero_done_width: got %b exp 0", bus.done); end
        n_vec++; if (en_cnt != 0)       begin n_err++; $display("FAIL zero_no_en: got %0d exp 0", en_cnt); end
        n_vec++; if (done_cnt != 1)     begin n_err++; $display("FAIL zero_done_cnt: got %0d exp 1", done_cnt); end
    endtask

    task automatic test_timeout();
        bit  got;
        op_t e;
        stub_on = 1'b0;
        clr_mon();
        sb_q.push_back(op_t'(12'hABC));
        drive_start(op_t'(12'hABC), Cnt_w'(1));
        wait_done(100, got);
        n_vec++; if (got !== 1'b1)      begin n_err++; $display("FAIL to_done_seen: got %b exp 1", got); end
        pop_exp(e);
        n_vec++; if (bus.result !== e)  begin n_err++; $display("FAIL to_result: got %0h exp %0h", bus.result[63:0], e[63:0]); end
        n_vec++; if (bus.err !== 1'b1)  begin n_err++; $display("FAIL to_err: got %b exp 1", bus.err); end
        n_vec++; if (bus.iter_cnt !== '0) begin n_err++; $display("FAIL to_iter_cnt: got %0d exp 0", bus.iter_cnt); end
        @(negedge clk);
        n_vec++; if (done_cyc - en_cyc != Timeout + 1) begin n_err++; $display("FAIL to_latency: got %0d exp %0d", done_cyc - en_cyc, Timeout + 1); end
        n_vec++; if (bus.err !== 1'b1)  begin n_err++; $display("FAIL to_err_sticky: got %b exp 1", bus.err); end
        stub_on = 1'b1;
        clr_mon();
        sb_q.push_back(op_t'(2));
        drive_start(op_t'(1), Cnt_w'(1));
        n_vec++; if (bus.err !== 1'b0)  begin n_err++; $display("FAIL to_err_cleared: got %b exp 0", bus.err); end
        wait_done(100, got);
        pop_exp(e);
        n_vec++; if (bus.result !== e)  begin n_err++; $display("FAIL to_rerun_result: got %0h exp %0h", bus.result[63:0], e[63:0]); end
        @(negedge clk);
    endtask

    task automatic test_coincide();
        bit  got;
        op_t e;
        stub_lat = Timeout;
        clr_mon();
        sb_q.push_back(op_t'(8'h52));
        drive_start(op_t'(8'h50), Cnt_w'(2));
        repeat (5) @(negedge clk);
        bus.a_in     = op_t'(16'hFFFF);
        bus.iter_num = Cnt_w'(1);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL co_busy: got %b exp 1", bus.busy); end
        n_vec++; if (bus.pa_a !== op_t'(8'h50)) begin n_err++; $display("FAIL co_pa_a_held: got %0h exp 50", bus.pa_a[63:0]); end
        wait_done(150, got);
        n_vec++; if (got !== 1'b1)      begin n_err++; $display("FAIL co_done_seen: got %b exp 1", got); end
        pop_exp(e);
        n_vec++; if (bus.result !== e)  begin n_err++; $display("FAIL co_result: got %0h exp %0h", bus.result[63:0], e[63:0]); end
        n_vec++; if (bus.err !== 1'b0)  begin n_err++; $display("FAIL co_err: got %b exp 0", bus.err); end
        n_vec++; if (bus.iter_cnt !== Cnt_w'(2)) begin n_err++; $display("FAIL co_iter_cnt: got %0d exp 2", bus.iter_cnt); end
        @(negedge clk);
        n_vec++; if (en_cnt != 2)       begin n_err++; $display("FAIL co_en_pulses: got %0d exp 2", en_cnt); end
        stub_lat = 12;
    endtask

    task automatic test_abort();
        int  k;
        op_t prev;
        prev = last_exp;
        clr_mon();
        drive_start(op_t'(12'h100), Cnt_w'(4));
        k = 0;
        while (en_cnt < 2 && k < 100) begin @(negedge clk); k++; end
        n_vec++; if (en_cnt < 2) begin n_err++; $display("FAIL ab_second_launch: got %0d exp 2", en_cnt); end
        k = 0;
        while (cyc < en_cyc + 5 && k < 20) begin @(negedge clk); k++; end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_vec++; if (bus.busy !== 1'b0)  begin n_err++; $display("FAIL ab_busy: got %b exp 0", bus.busy); end
        repeat (15) @(negedge clk);
        n_vec++; if (en_cnt != 2)        begin n_err++; $display("FAIL ab_en_cnt: got %0d exp 2", en_cnt); end
        n_vec++; if (done_cnt != 0)      begin n_err++; $display("FAIL ab_no_done: got %0d exp 0", done_cnt); end
        n_vec++; if (bus.pa_a !== op_t'(12'h101)) begin n_err++; $display("FAIL ab_no_capture: got %0h exp 101", bus.pa_a[63:0]); end
        n_vec++; if (bus.iter_cnt !== Cnt_w'(1))  begin n_err++; $display("FAIL ab_iter_cnt: got %0d exp 1", bus.iter_cnt); end
        n_vec++; if (bus.result !== prev) begin n_err++; $display("FAIL ab_result_kept: got %0h exp %0h", bus.result[63:0], prev[63:0]); end
        n_vec++; if (bus.err !== 1'b0)   begin n_err++; $display("FAIL ab_err_kept: got %b exp 0", bus.err); end
        @(negedge clk);
        bus.a_in     = op_t'(12'h999);
        bus.iter_num = Cnt_w'(0);
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        n_vec++; if (bus.done !== 1'b0)  begin n_err++; $display("FAIL sa_done: got %b exp 0", bus.done); end
        n_vec++; if (bus.pa_a !== op_t'(12'h101)) begin n_err++; $display("FAIL sa_pa_a: got %0h exp 101", bus.pa_a[63:0]); end
        repeat (3) @(negedge clk);
        n_vec++; if (done_cnt != 0 || en_cnt != 2) begin n_err++; $display("FAIL sa_idle: got done %0d en %0d exp 0 2", done_cnt, en_cnt); end
    endtask

    task automatic test_reset_mid();
        bit  got;
        op_t e;
        clr_mon();
        drive_start(op_t'(8'h40), Cnt_w'(3));
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        stub_cd = -1;
        n_vec++; if (bus.pa_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0)
            begin n_err++; $display("FAIL rm_ctrl: got en %b busy %b done %b err %b exp 0", bus.pa_en, bus.busy, bus.done, bus.err); end
        n_vec++; if (bus.pa_a !== '0 || bus.result !== '0 || bus.iter_cnt !== '0)
            begin n_err++; $display("FAIL rm_data: got pa_a %0h result %0h cnt %0d exp 0", bus.pa_a[63:0], bus.result[63:0], bus.iter_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clr_mon();
        sb_q.push_back(op_t'(8'h79));
        drive_start(op_t'(8'h77), Cnt_w'(2));
        wait_done(200, got);
        n_vec++; if (got !== 1'b1)      begin n_err++; $display("FAIL rm_done_seen: got %b exp 1", got); end
        pop_exp(e);
        n_vec++; if (bus.result !== e)  begin n_err++; $display("FAIL rm_result: got %0h exp %0h", bus.result[63:0], e[63:0]); end
        n_vec++; if (bus.iter_cnt !== Cnt_w'(2) || bus.err !== 1'b0)
            begin n_err++; $display("FAIL rm_status: got cnt %0d err %b exp 2 0", bus.iter_cnt, bus.err); end
        @(negedge clk);
        n_vec++; if (en_cnt != 2 || en_dbl != 0) begin n_err++; $display("FAIL rm_en: got %0d dbl %0d exp 2 0", en_cnt, en_dbl); end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.a_in      = '0;
        bus.iter_num  = '0;
        bus.pa_new_a  = '0;
        bus.pa_en_out = 1'b0;
        test_reset();
        test_iter3();
        test_zero();
        test_timeout();
        test_coincide();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t exp finish earlier", $time);
        $fatal(1);
    end
endmodule

// File: doc/phase_a_iter_ctrl.md
Name: phase_a_iter_ctrl

Overview:
- Initiator-side sequencer for the phase_a reduction responder.
- Loads a 3072-bit operand and launches phase_a with a single-cycle en pulse, holding the operand stable on the a bus.
- Waits for the en_out strobe and captures new_a in that exact cycle. Feeds the captured value back as the next operand.
- Repeats for a run-time number of iterations, then returns the final value with a done pulse. Includes a timeout watchdog and abort.

Parameters:
- Size, 3072, operand width; must match phase_a Size.
- Cnt_w, 7, width of iteration count and iter_num.
- Timeout, 255, max cycles from launch to en_out before error.
- To_w, 8, width of the watchdog counter; must hold Timeout.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a run; sampled only in IDLE
- abort  input  1  cancel a run; synchronous, any state
- a_in  input  Size  initial operand, latched on accepted start
- iter_num  input  Cnt_w  number of phase_a passes, latched on accepted start
- pa_a  output  Size  operand to phase_a a port; held stable for the whole pass
- pa_en  output  1  one-cycle launch pulse to phase_a en
- pa_new_a  input  Size  phase_a new_a; valid only while pa_en_out=1
- pa_en_out  input  1  phase_a completion strobe
- busy  output  1  high in LAUNCH and WAIT
- done  output  1  one-cycle completion pulse
- err  output  1  timeout flag; sticky until next accepted start
- result  output  Size  final operand; held until next accepted start
- iter_cnt  output  Cnt_w  passes completed in the current run

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - pa_a, pa_en, busy, done, err, result, iter_cnt and the watchdog all go to 0.
  - Asserting reset mid-run abandons the run immediately; pa_en drops to 0 at once.
- States: IDLE, LAUNCH, WAIT, FIN.
- IDLE:
  - start=1 and abort=0: latch a_in into pa_a and iter_num into the internal count; clear iter_cnt and err.
  - If latched iter_num==0: go to FIN with result=a_in.
  - Otherwise: go to LAUNCH.
  - start=1 and abort=1 in the same cycle: abort wins; the start is ignored.
- LAUNCH:
  - pa_en=1 for exactly this cycle; the watchdog is cleared.
  - Always go to WAIT next.
  - pa_en is never high two cycles in a row. phase_a edge-detects en, so the single-cycle pulse is mandatory.
- WAIT:
  - pa_en=0; the watchdog increments each cycle.
  - pa_en_out=1: capture pa_new_a into pa_a in that cycle, iter_cnt+=1.
    - If iter_cnt+1==iter_num: go to FIN with result=pa_new_a.
    - Otherwise: go to LAUNCH next cycle. There is always at least one pa_en-low cycle between pulses.
  - Watchdog reaches Timeout with no pa_en_out: set err=1, result=current pa_a, go to FIN.
  - pa_en_out and watchdog==Timeout in the same cycle: pa_en_out wins; no error.
- FIN: done=1 for one cycle, then go to IDLE.
- abort (any non-IDLE state):
  - Next state is IDLE; pa_en=0; done is not pulsed.
  - result and err keep their prior values; iter_cnt is frozen.
  - A late pa_en_out after abort is ignored.
- pa_en_out outside WAIT (IDLE, LAUNCH, FIN) is ignored.
- pa_a changes only on an accepted start or a capture in WAIT, so phase_a sees a constant a from launch through its internal sampling.
- start is ignored while busy or in FIN.
- Latency:
  - start to first pa_en: 1 cycle.
  - pa_en_out to next pa_en: 1 cycle.
  - Final pa_en_out to done: 1 cycle.
  - iter_num=0: done 1 cycle after start.

Test Plan:
- Stub phase_a with 12-cycle latency and new_a=a+1. a_in=5, iter_num=3 -> exactly 3 pa_en pulses, each 1 cycle wide; pa_a sequence 5,6,7; result=8; done one cycle; err=0; iter_cnt=3.
- iter_num=0, a_in=0x1234 -> no pa_en; done 1 cycle after start; result=0x1234; iter_cnt=0.
- Stub never asserts en_out, Timeout=20 -> err=1 and done exactly 20 WAIT cycles after launch; result=a_in. A second start clears err.
- pa_en_out coincident with watchdog==Timeout -> capture taken, err=0. Start pulse during WAIT -> ignored; iteration count and pa_a unaffected.
- Abort 5 cycles into WAIT of pass 2 of 4; stub still returns en_out later -> IDLE, no done, no capture, pa_en stays 0; start and abort together in IDLE -> stays IDLE.
- rst_n low mid-WAIT -> all outputs 0 immediately; after release, a new run with iter_num=2 completes normally with result=a_in+2.
